booth_seq_mult: RTL and testbench
=================================

// Module: booth_seq_mult
// PURPOSE
//  Sequential radix-2 Booth multiplier, parametrised in operand width, with a
//  per-operation signed/unsigned mode and a start/busy/done handshake.
//  Retires one Booth step per clock, so it trades latency for a single
//  (W+2)-bit adder/subtractor. It is a drop-in arithmetic unit for the lab
//  datapath/ALU. Results are exact for every operand pair, including the most
//  negative value.
// PARAMETERS
//  W      8   operand width in bits (W >= 2); product width is 2*W
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     asynchronous, active-high reset
//  start        in   1     request; sampled only in IDLE or DONE
//  signed_mode  in   1     1: a,b are two's complement; 0: unsigned; sampled with start
//  a            in   W     multiplicand, captured on accepted start
//  b            in   W     multiplier, captured on accepted start
//  busy         out  1     high while state == CALC
//  done         out  1     one-cycle pulse; product valid from this cycle
//  product      out  2*W   result; held until the next accepted start
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, busy=0, done=0, product=0, internal regs=0.
//    Reset mid-CALC aborts the operation; no done pulse is issued for it.
//  - States and transitions:
//    IDLE -> CALC on start. DONE -> CALC on start (back-to-back). DONE -> IDLE otherwise.
//    CALC -> DONE after the last step. start is ignored while in CALC.
//  - Load (accepted start edge): M = a extended to W+1 bits (sign-extended if
//    signed_mode, else zero-extended). Q = b extended the same way. Acc = 0,
//    q_m1 = 0, count = W+1.
//  - Each CALC cycle examines {Q[0],q_m1}:
//    01 -> Acc += M; 10 -> Acc -= M; 00/11 -> no operation.
//    Then {Acc,Q,q_m1} arithmetic-shifts right 1 and count decrements.
//    Acc is W+2 bits wide, so no intermediate overflow is possible.
//  - Latency: exactly W+1 CALC cycles. done=1 and product valid in the cycle
//    after the (W+1)th step, i.e. W+2 clock edges after the start edge.
//    busy is high for W+1 cycles.
//  - product = low 2*W bits of {Acc,Q} after the last step. In unsigned mode this
//    is a*b mod 2^(2W) = exact a*b. In signed mode it is the exact two's
//    complement a*b.
//  - done is registered and high only in DONE; product changes only on the
//    DONE entry edge.
// CONFIGURATION
//  BOOTH_EARLY_TERM_EN defined:
//    - At the start of each CALC cycle, let k = the remaining count. If the
//      unprocessed bits Q[k-1:0] and q_m1 are all 0 or all 1, that cycle does
//      no add/subtract; instead it arithmetic-shifts {Acc,Q} right by k and
//      goes to DONE.
//    - Latency is variable, from 1 to W+1 CALC cycles. The result is identical.
//  BOOTH_EARLY_TERM_EN undefined:
//    - Fixed W+1-cycle latency.
//    - No early-termination comparator or barrel shifter is synthesised.
// TESTING (W=8; cycle counts given without BOOTH_EARLY_TERM_EN unless noted)
//  1. signed, a=0x80 (-128), b=0x80 (-128)
//     -> product=0x4000 (16384); done 10 edges after the start edge.
//  2. unsigned, a=0xFF, b=0xFF -> product=0xFE01 (65025).
//  3. signed, a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
//     unsigned, a=0xFD, b=0x05 -> product=0x04F1 (1265).
//  4. start with a=3,b=4, then pulse start with a=9,b=9 while busy
//     -> second request ignored; product=0x000C.
//     Then start in the DONE cycle with a=2,b=5 -> busy with no IDLE cycle; product=0x000A.
//  5. Assert reset during the 4th CALC cycle -> busy=0, done=0, product=0
//     immediately. No done pulse until a new start, which then completes normally.
//  6. With BOOTH_EARLY_TERM_EN: signed a=0x07, b=0x00
//     -> done 2 edges after start, product=0.
//     signed a=0x07, b=0xFF -> product=0xFFF9 (-7); done earlier than 10 edges.
//     The product must match the non-early build for the same operands.

Source files
------------

// File: rtl/booth_seq_mult_if.sv
// Handshake and data bundle for booth_seq_mult: request side (start, mode, operands)
// and result side (busy, done, product).
interface booth_seq_mult_if #(
    parameter int W = 8
);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per operation.
// Latency: W+1 CALC cycles, done pulses on the next; BOOTH_EARLY_TERM_EN makes it 1..W+1.
// Backpressure: start is accepted only in IDLE or DONE and ignored while busy.
module booth_seq_mult #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    booth_seq_mult_if.slave  bus
);
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W+1:0]   acc_q, acc_d;
    logic [W:0]     q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [W:0]     m_q, m_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*W-1:0] product_q, product_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W+1:0]   m_ext;
    logic [W+1:0]   sum;
    logic           last_step;
`ifdef BOOTH_EARLY_TERM_EN
    logic [W:0]     rem_mask;
    logic           early;
    logic [2*W+2:0] shifted;
`endif

    assign m_ext = {m_q[W], m_q};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        sum       = acc_q;
        last_step = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
        rem_mask  = '0;
        early     = 1'b0;
        shifted   = '0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    m_d     = {bus.signed_mode & bus.a[W-1], bus.a};
                    q_d     = {bus.signed_mode & bus.b[W-1], bus.b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    count_d = CW'(W + 1);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                unique case ({q_q[0], qm1_q})
                    2'b01:   sum = acc_q + m_ext;
                    2'b10:   sum = acc_q - m_ext;
                    default: sum = acc_q;
                endcase
                acc_d     = {sum[W+1], sum[W+1:1]};
                q_d       = {sum[0], q_q[W:1]};
                qm1_d     = q_q[0];
                count_d   = count_q - 1'b1;
                last_step = (count_q == CW'(1));
`ifdef BOOTH_EARLY_TERM_EN
                // Remaining multiplier bits all equal to q_m1: every remaining step is a pure shift.
                rem_mask = {(W+1){1'b1}} >> (CW'(W + 1) - count_q);
                early    = qm1_q ? ((q_q & rem_mask) == rem_mask) : ((q_q & rem_mask) == '0);
                shifted  = $signed({acc_q, q_q}) >>> count_q;
                if (early) begin
                    acc_d     = shifted[2*W+2:W+1];
                    q_d       = shifted[W:0];
                    qm1_d     = 1'b0;
                    count_d   = '0;
                    last_step = 1'b1;
                end
`endif
                if (last_step) begin
                    product_d = {acc_d[W-2:0], q_d};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector bench for booth_seq_mult (W=8); latency counts the start edge as edge 1.
module tb_booth_seq_mult;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    booth_seq_mult_if #(.W(W)) bus ();

    booth_seq_mult #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and waits for done; optionally pokes a second start mid-CALC.
    task automatic do_op(input bit sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit no_wait, input int poke,
                         output int prod, output int edges, output int busy_cycles,
                         output int prod_first);
        if (!no_wait) @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.a           = aa;
        bus.b           = bb;
        @(posedge clk);
        edges       = 1;
        busy_cycles = 0;
        @(negedge clk);
        prod_first = int'(bus.product);
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cycles++;
            if (poke != 0 && busy_cycles == poke) begin
                bus.start = 1'b1;
                bus.a     = 8'd9;
                bus.b     = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("op_timeout", int'(edges < 100), 1);
        prod = int'(bus.product);
    endtask

    initial begin
        int p, e, bc, pf;
        bit seen_done;

        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_product", int'(bus.product), 0);
        reset = 1'b0;

        // 1: most negative squared
        do_op(1'b1, 8'h80, 8'h80, 1'b0, 0, p, e, bc, pf);
        check("t1_product", p, 'h4000);
        check("t1_latency", e, 10);
        check("t1_busy_cycles", bc, 9);
        @(negedge clk);
        check("t1_done_pulse", int'(bus.done), 0);
        check("t1_product_held", int'(bus.product), 'h4000);

        // 2-3: signed/unsigned mix
        do_op(1'b0, 8'hFF, 8'hFF, 1'b0, 0, p, e, bc, pf);
        check("t2_unsigned_ff", p, 'hFE01);
        do_op(1'b1, 8'hFD, 8'h05, 1'b0, 0, p, e, bc, pf);
        check("t3_signed", p, 'hFFF1);
        do_op(1'b0, 8'hFD, 8'h05, 1'b0, 0, p, e, bc, pf);
        check("t3_unsigned", p, 'h04F1);
        do_op(1'b1, 8'h7F, 8'h80, 1'b0, 0, p, e, bc, pf);
        check("t3_signed_max_min", p, 'hC080);

        // 4: start ignored while busy, then back-to-back start in DONE
        do_op(1'b0, 8'd3, 8'd4, 1'b0, 3, p, e, bc, pf);
        check("t4_ignore_busy", p, 'h000C);
        check("t4_latency", e, 10);
        do_op(1'b0, 8'd2, 8'd5, 1'b1, 0, p, e, bc, pf);
        check("t4_b2b_product", p, 'h000A);
        check("t4_b2b_busy_cycles", bc, 9);
        check("t4_b2b_product_held", pf, 'h000C);

        // 5: reset during the 4th CALC cycle
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.a           = 8'd7;
        bus.b           = 8'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("t5_rst_busy", int'(bus.busy), 0);
        check("t5_rst_done", int'(bus.done), 0);
        check("t5_rst_product", int'(bus.product), 0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("t5_no_done_after_abort", int'(seen_done), 0);
        do_op(1'b1, 8'hFD, 8'hFD, 1'b0, 0, p, e, bc, pf);
        check("t5_recover_product", p, 'h0009);
        check("t5_recover_latency", e, 10);

        // 6: early-termination candidates; products identical in both builds
        do_op(1'b1, 8'h07, 8'h00, 1'b0, 0, p, e, bc, pf);
        check("t6_zero_product", p, 0);
`ifdef BOOTH_EARLY_TERM_EN
        check("t6_zero_latency", e, 2);
`else
        check("t6_zero_latency", e, 10);
`endif
        do_op(1'b1, 8'h07, 8'hFF, 1'b0, 0, p, e, bc, pf);
        check("t6_neg1_product", p, 'hFFF9);
`ifdef BOOTH_EARLY_TERM_EN
        check("t6_neg1_early", int'(e < 10), 1);
`else
        check("t6_neg1_latency", e, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
